// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
// Consumes PS/2 set-2 bytes from an upstream FIFO and tracks the most recently
// pressed key, with make/break pulses, a press counter and a sticky overflow flag.
// Optional macro PS2_DECODER_ASCII_EN: when defined, ascii is driven from a
// registered lowercase lookup (a-z, 0-9, space, enter); otherwise ascii is 0x00.
//
// Handshake to upstream: ready=1 means data holds a valid FIFO head byte. The
// decoder samples it only in H_IDLE, then pulses nextdata_n low for exactly one
// clk. It waits one more clk (H_SETTLE) so the FIFO can advance before ready is
// looked at again.
module ps2_scancode_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       ready,
    input  logic       overflow,
    output logic       nextdata_n,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_down,
    output logic [7:0] ascii,
    output logic       make_pulse,
    output logic       break_pulse,
    output logic [7:0] press_cnt,
    output logic       ovf_sticky,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        H_IDLE   = 2'd0,
        H_POP    = 2'd1,
        H_SETTLE = 2'd2
    } h_state_t;

    h_state_t h_state;
    h_state_t h_next;

    logic e0_seen;
    logic f0_seen;

    logic capture;
    logic is_e0;
    logic is_f0;
    logic same_key;
    logic rel_hit;
    logic make_new;

    assign dbg_state = h_state;

    // Byte classification for the edge on which a byte is taken from upstream.
    assign capture  = (h_state == H_IDLE) && ready;
    assign is_e0    = (data == 8'hE0);
    assign is_f0    = (data == 8'hF0);
    assign same_key = (data == key_code) && (e0_seen == key_ext);
    assign rel_hit  = capture && !is_e0 && !is_f0 && f0_seen && key_down && same_key;
    assign make_new = capture && !is_e0 && !is_f0 && !f0_seen && !(key_down && same_key);

    // Handshake next-state logic.
    always_comb begin
        h_next = h_state;
        case (h_state)
            H_IDLE:   if (ready) h_next = H_POP;
            H_POP:    h_next = H_SETTLE;
            H_SETTLE: h_next = H_IDLE;
            default:  h_next = H_IDLE;
        endcase
    end

    // Handshake state register and registered pop strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_state    <= H_IDLE;
            nextdata_n <= 1'b1;
        end else begin
            h_state    <= h_next;
            nextdata_n <= !capture;
        end
    end

    // Protocol decode: prefix flags, key tracking, pulses and press counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_seen     <= 1'b0;
            f0_seen     <= 1'b0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_down    <= 1'b0;
            make_pulse  <= 1'b0;
            break_pulse <= 1'b0;
            press_cnt   <= 8'h00;
        end else begin
            make_pulse  <= 1'b0;
            break_pulse <= 1'b0;
            if (capture) begin
                if (is_e0) begin
                    e0_seen <= 1'b1;
                end else if (is_f0) begin
                    f0_seen <= 1'b1;
                end else if (f0_seen) begin
                    // Release of anything other than the tracked key is dropped.
                    if (rel_hit) begin
                        key_down    <= 1'b0;
                        break_pulse <= 1'b1;
                    end
                    e0_seen <= 1'b0;
                    f0_seen <= 1'b0;
                end else begin
                    // A held key re-sent by typematic repeat is not a new press.
                    if (make_new) begin
                        key_code   <= data;
                        key_ext    <= e0_seen;
                        key_down   <= 1'b1;
                        make_pulse <= 1'b1;
                        press_cnt  <= press_cnt + 8'd1;
                    end
                    e0_seen <= 1'b0;
                end
            end
        end
    end

    // Overflow is latched on any clk, independent of the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_sticky <= 1'b0;
        else if (overflow) ovf_sticky <= 1'b1;
    end

`ifdef PS2_DECODER_ASCII_EN
    function automatic logic [7:0] ascii_lut(input logic [7:0] code);
        logic [7:0] a;
        a = 8'h00;
        case (code)
            8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
            8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
            8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
            8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
            8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
            8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
            8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
            8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
            8'h3E: a = 8'h38; 8'h46: a = 8'h39;
            8'h29: a = 8'h20;
            8'h5A: a = 8'h0D;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    // ASCII follows key_code; extended keys never map.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ascii <= 8'h00;
        else if (make_new) ascii <= e0_seen ? 8'h00 : ascii_lut(data);
    end
`else
    assign ascii = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Testbench for ps2_scancode_decoder: directed byte sequences, expected
// make/break events queued by the driver and checked by a pulse monitor.
module tb_ps2_scancode_decoder;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       nextdata_n;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_down;
    logic [7:0] ascii;
    logic       make_pulse;
    logic       break_pulse;
    logic [7:0] press_cnt;
    logic       ovf_sticky;
    logic [1:0] dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    // Event word: {break, make, ext, code}
    logic [10:0] exp_q[$];

`ifdef PS2_DECODER_ASCII_EN
    localparam logic [7:0] ASCII_A = 8'h61;
    localparam logic [7:0] ASCII_B = 8'h62;
`else
    localparam logic [7:0] ASCII_A = 8'h00;
    localparam logic [7:0] ASCII_B = 8'h00;
`endif

    ps2_scancode_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .data        (data),
        .ready       (ready),
        .overflow    (overflow),
        .nextdata_n  (nextdata_n),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_down    (key_down),
        .ascii       (ascii),
        .make_pulse  (make_pulse),
        .break_pulse (break_pulse),
        .press_cnt   (press_cnt),
        .ovf_sticky  (ovf_sticky),
        .dbg_state   (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && (make_pulse || break_pulse)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got mk=%0b brk=%0b code=%0h with empty queue",
                         make_pulse, break_pulse, key_code);
            end else begin
                chk("event", {break_pulse, make_pulse, key_ext, key_code}, exp_q.pop_front());
            end
        end
    end

    task automatic push_make(input logic ext, input logic [7:0] code);
        exp_q.push_back({1'b0, 1'b1, ext, code});
    endtask

    task automatic push_break(input logic ext, input logic [7:0] code);
        exp_q.push_back({1'b1, 1'b0, ext, code});
    endtask

    // Driver: present one byte, wait for its pop, check the strobe is one clk wide.
    task automatic send_byte(input logic [7:0] b);
        bit found;
        found = 0;
        data  = b;
        ready = 1'b1;
        for (int k = 0; k < 8 && !found; k++) begin
            @(negedge clk);
            if (!nextdata_n) found = 1;
        end
        ready = 1'b0;
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pop_timeout: got no nextdata_n low for byte %0h", b);
        end
        @(negedge clk);
        if (nextdata_n !== 1'b1) chk("pop_width", nextdata_n, 1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int lows;
        bit prev_low;
        bit dbl;
        rst = 1'b1; data = 8'h00; ready = 1'b0; overflow = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_nextdata_n", nextdata_n, 1);
        chk("rst_key_code", key_code, 8'h00);
        chk("rst_key_ext", key_ext, 0);
        chk("rst_key_down", key_down, 0);
        chk("rst_ascii", ascii, 8'h00);
        chk("rst_press_cnt", press_cnt, 8'h00);
        chk("rst_ovf", ovf_sticky, 0);
        chk("rst_pulses", {make_pulse, break_pulse}, 2'b00);
        chk("rst_state", dbg_state, 2'd0);

        // Single press of 'a'
        push_make(1'b0, 8'h1C);
        send_byte(8'h1C);
        chk("a_key_code", key_code, 8'h1C);
        chk("a_key_down", key_down, 1);
        chk("a_press_cnt", press_cnt, 8'd1);
        chk("a_ascii", ascii, ASCII_A);

        // Typematic repeats then release
        send_byte(8'h1C);
        send_byte(8'h1C);
        push_break(1'b0, 8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        chk("rep_press_cnt", press_cnt, 8'd1);
        chk("rep_key_down", key_down, 0);
        chk("rep_key_code", key_code, 8'h1C);

        // Extended key press and release
        push_make(1'b1, 8'h75);
        send_byte(8'hE0);
        send_byte(8'h75);
        chk("ext_key_ext", key_ext, 1);
        chk("ext_ascii", ascii, 8'h00);
        chk("ext_press_cnt", press_cnt, 8'd2);
        push_break(1'b1, 8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        chk("ext_key_down", key_down, 0);

        // Second key replaces first; first key's release is ignored
        push_make(1'b0, 8'h1C);
        send_byte(8'h1C);
        push_make(1'b0, 8'h32);
        send_byte(8'h32);
        send_byte(8'hF0);
        send_byte(8'h1C);
        chk("repl_key_code", key_code, 8'h32);
        chk("repl_press_cnt", press_cnt, 8'd4);
        chk("repl_key_down", key_down, 1);
        chk("repl_ascii", ascii, ASCII_B);
        // Release with wrong prefix is ignored, correct one breaks
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h32);
        chk("ext_mismatch_down", key_down, 1);
        push_break(1'b0, 8'h32);
        send_byte(8'hF0);
        send_byte(8'h32);
        chk("b_release_down", key_down, 0);

        // Overflow is sticky
        overflow = 1'b1;
        @(negedge clk);
        overflow = 1'b0;
        chk("ovf_set", ovf_sticky, 1);
        send_byte(8'hE0);
        repeat (5) @(negedge clk);
        chk("ovf_hold", ovf_sticky, 1);

        // F0 then reset: following 1C is a make; ready held high continuously
        send_byte(8'hF0);
        do_reset();
        chk("ovf_cleared", ovf_sticky, 0);
        chk("rst2_press_cnt", press_cnt, 8'd0);
        push_make(1'b0, 8'h1C);
        data = 8'h1C;
        ready = 1'b1;
        lows = 0; prev_low = 0; dbl = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (!nextdata_n) begin
                lows++;
                if (prev_low) dbl = 1;
            end
            prev_low = !nextdata_n;
        end
        ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("cont_pop_count", lows, 4);
        chk("cont_no_double_low", dbl, 0);
        chk("cont_key_down", key_down, 1);
        chk("cont_press_cnt", press_cnt, 8'd1);

        // Reset during H_POP: strobe released at once, no second pop
        do_reset();
        push_make(1'b0, 8'h1C);
        data = 8'h1C;
        ready = 1'b1;
        @(negedge clk);
        chk("pop_low_before_rst", nextdata_n, 0);
        ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_nextdata_n", nextdata_n, 1);
        chk("rst_async_press_cnt", press_cnt, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        lows = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (!nextdata_n) lows++;
        end
        chk("no_second_pop", lows, 0);

        // 256 presses wrap the counter
        for (int i = 0; i < 256; i++) begin
            logic [7:0] c;
            c = (i % 2 == 0) ? 8'h32 : 8'h1C;
            push_make(1'b0, c);
            send_byte(c);
            if (i == 254) chk("cnt_ff", press_cnt, 8'hFF);
        end
        chk("cnt_wrap", press_cnt, 8'h00);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
